// File: rtl/hub75_row_driver.sv
// HUB75 row sequencer: per request, shift one row of column words into the panel,
// latch it, unblank for the requested on-time, then pulse done.
//
// state | meaning
// IDLE  | ready for a request, panel blanked
// SHIFT | reading the line buffer and clocking columns into the panel
// LATCH | latch-enable pulse and row address update
// SHOW  | panel unblanked while the on-time counter runs down
module hub75_row_driver #(
  parameter int N_BANKS    = 2,
  parameter int N_ROWS     = 32,
  parameter int N_COLS     = 64,
  parameter int N_CHANS    = 3,
  parameter int ON_W       = 16,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [LOG_N_ROWS-1:0]        req_row,
  input  logic [ON_W-1:0]              req_ontime,
  output logic                         rd_en,
  output logic [LOG_N_COLS-1:0]        rd_addr,
  input  logic [N_BANKS*N_CHANS-1:0]   rd_data,
  output logic                         done,
  output logic                         err_seq,
  output logic [LOG_N_ROWS-1:0]        phy_addr,
  output logic                         phy_addr_inc,
  output logic                         phy_addr_rst,
  output logic [N_BANKS*N_CHANS-1:0]   phy_data,
  output logic                         phy_clk,
  output logic                         phy_le,
  output logic                         phy_blank
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, SHOW} state_t;

  localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LOG_N_ROWS-1:0] LAST_ROW = LOG_N_ROWS'(N_ROWS - 1);

  state_t                state;
  logic [LOG_N_ROWS-1:0] row;
  logic [LOG_N_ROWS-1:0] prev_row;
  logic [ON_W-1:0]       ontime;
  logic [ON_W-1:0]       timer;
  logic                  rd_en_q;
  logic [LOG_N_ROWS-1:0] next_row;

  assign next_row = (prev_row == LAST_ROW) ? '0 : prev_row + LOG_N_ROWS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      prev_row     <= LAST_ROW;
      ontime       <= '0;
      timer        <= '0;
      rd_en_q      <= 1'b0;
      req_ready    <= 1'b1;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      done         <= 1'b0;
      err_seq      <= 1'b0;
      phy_addr     <= '0;
      phy_addr_inc <= 1'b0;
      phy_addr_rst <= 1'b0;
      phy_data     <= '0;
      phy_clk      <= 1'b0;
      phy_le       <= 1'b0;
      phy_blank    <= 1'b1;
    end else begin
      rd_en_q      <= rd_en;
      phy_clk      <= 1'b0;
      phy_le       <= 1'b0;
      phy_addr_inc <= 1'b0;
      phy_addr_rst <= 1'b0;
      err_seq      <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            row       <= req_row;
            ontime    <= req_ontime;
            req_ready <= 1'b0;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (rd_en) begin
            if (rd_addr == LAST_COL) begin
              rd_en   <= 1'b0;
              rd_addr <= '0;
            end else begin
              rd_addr <= rd_addr + LOG_N_COLS'(1);
            end
          end
          // read data arrives one cycle after the strobe
          if (rd_en_q) begin
            phy_data <= rd_data;
            phy_clk  <= 1'b1;
          end
          if (phy_clk && !rd_en_q) begin
            phy_le   <= 1'b1;
            phy_addr <= row;
            prev_row <= row;
            state    <= LATCH;
            if (row == '0)
              phy_addr_rst <= 1'b1;
            else if (row == next_row)
              phy_addr_inc <= 1'b1;
            else if (row != prev_row)
              err_seq <= 1'b1;
          end
        end
        LATCH: begin
          if (ontime == '0) begin
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            phy_blank <= 1'b0;
            timer     <= ontime - ON_W'(1);
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (timer == '0) begin
            phy_blank <= 1'b1;
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer - ON_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_row_driver.sv
// Directed bench for hub75_row_driver with a 4-column panel; expected timing is
// derived from the accept cycle of each request.
module tb_hub75_row_driver;
  localparam int N_COLS = 4;
  localparam int DW     = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_row;
  logic [15:0]   req_ontime;
  logic          rd_en;
  logic [1:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err_seq;
  logic [4:0]    phy_addr;
  logic          phy_addr_inc;
  logic          phy_addr_rst;
  logic [DW-1:0] phy_data;
  logic          phy_clk;
  logic          phy_le;
  logic          phy_blank;

  logic [DW-1:0] lbuf [N_COLS];
  int vectors = 0;
  int miscompares = 0;

  hub75_row_driver #(.N_COLS(N_COLS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_ontime(req_ontime),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .err_seq(err_seq),
    .phy_addr(phy_addr), .phy_addr_inc(phy_addr_inc), .phy_addr_rst(phy_addr_rst),
    .phy_data(phy_data), .phy_clk(phy_clk), .phy_le(phy_le), .phy_blank(phy_blank)
  );

  always #5 clk = ~clk;

  // line buffer: word valid one cycle after the strobe, junk otherwise
  always @(posedge clk)
    rd_data <= rd_en ? lbuf[rd_addr] : DW'($urandom);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check(tag, 32'({req_ready, rd_en, rd_addr, done, err_seq, phy_addr, phy_addr_inc,
                    phy_addr_rst, phy_data, phy_clk, phy_le, phy_blank}),
          32'({1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1}));
  endtask

  // Entered at a negedge where the DUT is idle; returns at the negedge of the done cycle.
  task automatic do_row(input int row, input int ontime, input bit ei, input bit er,
                        input bit ee, input bit hold);
    int last;
    logic [8:0] exp;
    last = N_COLS + 4 + ontime;
    for (int i = 0; i < N_COLS; i++) lbuf[i] = DW'(row * 7 + i * 13 + 5);
    req_valid  = 1'b1;
    req_row    = 5'(row);
    req_ontime = 16'(ontime);
    check($sformatf("accept_ready row%0d", row), 32'(req_ready), 32'd1);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          req_row    = 5'(row + 9);
          req_ontime = 16'h1234;
        end else begin
          req_valid = 1'b0;
        end
      end
      exp = {k == last, k <= N_COLS, (k >= 3) && (k <= N_COLS + 2), k == N_COLS + 3,
             ei && (k == N_COLS + 3), er && (k == N_COLS + 3), ee && (k == N_COLS + 3),
             !((k >= N_COLS + 4) && (k <= N_COLS + 3 + ontime)), k == last};
      check($sformatf("ctl row%0d k%0d", row, k),
            32'({req_ready, rd_en, phy_clk, phy_le, phy_addr_inc, phy_addr_rst, err_seq,
                 phy_blank, done}), 32'(exp));
      if (k <= N_COLS)
        check($sformatf("rd_addr row%0d k%0d", row, k), 32'(rd_addr), 32'(k - 1));
      if (k >= 3 && k <= N_COLS + 2)
        check($sformatf("data row%0d k%0d", row, k), 32'(phy_data), 32'(lbuf[k - 3]));
      if (k == N_COLS + 3 || k == last)
        check($sformatf("addr row%0d k%0d", row, k), 32'(phy_addr), 32'(row));
      if (k == last)
        check($sformatf("data_hold row%0d", row), 32'(phy_data), 32'(lbuf[N_COLS - 1]));
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_row    = '0;
    req_ontime = '0;
    for (int i = 0; i < N_COLS; i++) lbuf[i] = '0;
    #1;
    check_reset("reset_values");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle_after_reset");

    // single row, then a full 0..31,0 sweep
    do_row(0, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int r = 1; r < 32; r++) do_row(r, r % 3 + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_row(0, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // sequence error and repeat
    do_row(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_row(2, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_row(5, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_row(5, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // on-time extremes
    do_row(6, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_row(7, 65535, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("idle_ready", 32'({req_ready, phy_blank, done}), 32'b110);

    // request valid held high: each accept lands on the previous done cycle
    do_row(8, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    do_row(9, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_row(10, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_row(11, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // reset during SHIFT
    req_valid  = 1'b1;
    req_row    = 5'd4;
    req_ontime = 16'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_shift_clk", 32'(phy_clk), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("rst_in_shift");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("no_done_after_shift_rst", 32'({done, req_ready, phy_blank}), 32'b011);

    // reset during SHOW
    req_valid  = 1'b1;
    req_row    = 5'd1;
    req_ontime = 16'd10;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < N_COLS + 6; i++) @(negedge clk);
    check("pre_rst_show_blank", 32'(phy_blank), 32'd0);
    rst = 1'b1;
    #1;
    check_reset("rst_in_show");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("no_done_after_show_rst", 32'({done, req_ready, phy_blank}), 32'b011);

    do_row(0, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    do_row(1, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
